port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter.sv | 121 ++++++++++++
 tb/tb_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/port_arbiter.sv
// Four-requester credit-based arbiter feeding one downstream path.
// Round-robin grant over one-entry buffers, gated by a downstream credit count.
module port_arbiter #(
  parameter int PATH_WIDTH  = 64,
  parameter int INIT_CREDIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              in_valid,
  input  logic [4*PATH_WIDTH-1:0] in_data,
  output logic [3:0]              in_credit,
  input  logic                    out_credit,
  output logic                    out_valid,
  output logic [PATH_WIDTH-1:0]   out_data,
  output logic [1:0]              out_src,
  output logic                    err
);

  localparam logic [1:0] INIT_CNT = 2'(INIT_CREDIT);

  logic [3:0]            full;
  logic [3:0]            owed;
  logic [PATH_WIDTH-1:0] buf_q [4];
  logic [1:0]            cnt;
  logic [1:0]            ptr;

  logic [3:0] issue;
  logic [3:0] take;
  logic [3:0] drop;

  always_comb begin
    issue = '0;
    take  = '0;
    drop  = '0;
    for (int i = 0; i < 4; i++) begin
      issue[i] = ~full[i] & ~owed[i];
      take[i]  = in_valid[i] & ~full[i] & owed[i];
      drop[i]  = in_valid[i] & ~take[i];
    end
  end

  // Search uses registered full bits, so a word captured this edge waits one cycle.
  logic       found;
  logic [1:0] gnt;
  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    gnt   = ptr;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && full[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  logic       send;
  logic [3:0] gnt_oh;

  always_comb begin
    send   = found && (cnt != 2'd0);
    gnt_oh = send ? (4'b0001 << gnt) : 4'b0000;
  end

  logic       inc_only;
  logic       dec_only;
  logic       cnt_ovf;
  logic [1:0] cnt_nxt;

  always_comb begin
    inc_only = out_credit & ~send;
    dec_only = send & ~out_credit;
    cnt_ovf  = inc_only & (cnt == 2'd3);
    cnt_nxt  = cnt;
    unique case (1'b1)
      inc_only: cnt_nxt = cnt_ovf ? cnt : cnt + 2'd1;
      dec_only: cnt_nxt = cnt - 2'd1;
      default:  cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      owed      <= '0;
      in_credit <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err       <= 1'b0;
      ptr       <= '0;
      cnt       <= INIT_CNT;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      full      <= (full | take) & ~gnt_oh;
      owed      <= (owed | issue) & ~take;
      in_credit <= issue;
      out_valid <= send;
      cnt       <= cnt_nxt;
      if (send) begin
        out_data <= buf_q[gnt];
        out_src  <= gnt;
        ptr      <= gnt + 2'd1;
      end
      if ((|drop) || cnt_ovf) begin
        err <= 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (take[i]) begin
          buf_q[i] <= in_data[i*PATH_WIDTH +: PATH_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: credits, round-robin order,
// downstream credit gating, drop/overflow errors and mid-run reset.
module tb_port_arbiter;

  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_credit;
  logic           out_credit;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           err;

  int n_cmp = 0;
  int n_bad = 0;

  port_arbiter #(
    .PATH_WIDTH (W),
    .INIT_CREDIT(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_credit (in_credit),
    .out_credit(out_credit),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
    in_valid[i]       = 1'b1;
  endtask

  task automatic idle();
    in_valid = 4'b0000;
    in_data  = '0;
  endtask

  task automatic sent(input string tag,
                      input logic [1:0] src,
                      input logic [W-1:0] d);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_src"}, 64'(out_src), 64'(src));
    chk({tag, "_data"}, out_data, d);
  endtask

  initial begin
    rst        = 1'b1;
    out_credit = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_in_credit", 64'(in_credit), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    rst = 1'b0;

    tick();
    chk("rel_credit_all", 64'(in_credit), 64'hf);
    tick();
    chk("rel_credit_once", 64'(in_credit), 64'h0);
    chk("rel_out_valid", 64'(out_valid), 64'h0);

    // single word from requester 2, one downstream credit
    put(2, 64'hA5);
    tick();
    idle();
    chk("a5_no_same_edge", 64'(out_valid), 64'h0);
    tick();
    sent("a5_send", 2'd2, 64'hA5);
    chk("a5_no_credit_yet", 64'(in_credit), 64'h0);
    tick();
    chk("a5_valid_drop", 64'(out_valid), 64'h0);
    chk("a5_credit_back", 64'(in_credit), 64'h4);
    chk("a5_err", 64'(err), 64'h0);

    // counter at 0: all full, nothing sent until one credit
    for (int i = 0; i < 4; i++) put(i, 64'h10 + 64'(i));
    tick();
    idle();
    chk("c0_hold_a", 64'(out_valid), 64'h0);
    tick();
    chk("c0_hold_b", 64'(out_valid), 64'h0);
    tick();
    chk("c0_hold_c", 64'(out_valid), 64'h0);
    out_credit = 1'b1;
    tick();
    out_credit = 1'b0;
    chk("c0_credit_edge", 64'(out_valid), 64'h0);
    tick();
    sent("c0_one", 2'd3, 64'h13);
    tick();
    chk("c0_only_one", 64'(out_valid), 64'h0);
    chk("c0_credit3", 64'(in_credit), 64'h8);

    // out_credit every cycle: drain the remaining three in order
    out_credit = 1'b1;
    tick();
    chk("rr_c_up", 64'(out_valid), 64'h0);
    tick();
    sent("rr_0", 2'd0, 64'h10);
    tick();
    sent("rr_1", 2'd1, 64'h11);
    chk("rr_cr0", 64'(in_credit), 64'h1);
    tick();
    sent("rr_2", 2'd2, 64'h12);
    chk("rr_cr1", 64'(in_credit), 64'h2);
    tick();
    chk("rr_empty", 64'(out_valid), 64'h0);
    out_credit = 1'b0;

    // refill; pointer now at 3
    for (int i = 0; i < 4; i++) put(i, 64'h20 + 64'(i));
    tick();
    idle();
    chk("rf_cap", 64'(out_valid), 64'h0);
    out_credit = 1'b1;
    tick();
    sent("rf_3", 2'd3, 64'h23);
    tick();
    sent("rf_0", 2'd0, 64'h20);
    tick();
    sent("rf_1", 2'd1, 64'h21);
    tick();
    sent("rf_2", 2'd2, 64'h22);
    out_credit = 1'b0;
    tick();
    chk("rf_done", 64'(out_valid), 64'h0);
    chk("rf_err", 64'(err), 64'h0);

    // second word to requester 1 without a fresh credit
    put(1, 64'hBEEF);
    tick();
    put(1, 64'hDEAD);
    tick();
    idle();
    sent("dup_first", 2'd1, 64'hBEEF);
    chk("dup_err", 64'(err), 64'h1);
    tick();
    chk("dup_valid_off", 64'(out_valid), 64'h0);
    chk("dup_credit", 64'(in_credit), 64'h2);
    tick();
    chk("dup_sticky", 64'(err), 64'h1);

    // use the last credit, then leave an unsent word in buffer 3
    put(0, 64'h33);
    tick();
    idle();
    tick();
    sent("pre_rst", 2'd0, 64'h33);
    tick();
    put(3, 64'h44);
    tick();
    idle();
    tick();
    chk("pre_rst_idle", 64'(out_valid), 64'h0);

    rst = 1'b1;
    #1;
    chk("arst_err", 64'(err), 64'h0);
    chk("arst_data", out_data, 64'h0);
    chk("arst_src", 64'(out_src), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rel2_credit", 64'(in_credit), 64'hf);
    chk("rel2_valid", 64'(out_valid), 64'h0);
    tick();
    chk("rel2_credit_off", 64'(in_credit), 64'h0);
    tick();
    chk("rel2_discard", 64'(out_valid), 64'h0);

    // raise counter 1 -> 3, then overflow
    out_credit = 1'b1;
    tick();
    tick();
    chk("ovf_at3_ok", 64'(err), 64'h0);
    tick();
    out_credit = 1'b0;
    chk("ovf_err", 64'(err), 64'h1);

    // counter saturated at 3: exactly three sends
    for (int i = 0; i < 4; i++) put(i, 64'h50 + 64'(i));
    tick();
    idle();
    tick();
    sent("sat_0", 2'd0, 64'h50);
    tick();
    sent("sat_1", 2'd1, 64'h51);
    tick();
    sent("sat_2", 2'd2, 64'h52);
    tick();
    chk("sat_stop", 64'(out_valid), 64'h0);
    chk("sat_err", 64'(err), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
